// File: rtl/switch_mem_regs.sv
`default_nettype none
// ============================================================================
// Module   : switch_mem_regs
// Brief    : Four 8-bit configuration registers behind a simple strobe-based
//            access port. Writes can be locked out, reads return data one
//            cycle later, accepted writes are counted (saturating), and a
//            duplicate detector flags any two registers holding equal values.
// Revision : 1.0 - initial release
// ============================================================================
module switch_mem_regs #(
    parameter logic [7:0] REG_RESET_VAL = 8'h00,
    parameter int         CNT_W         = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             mem_en,
    input  logic             mem_rd_wr,
    input  logic [1:0]       mem_add,
    input  logic [7:0]       mem_data,
    input  logic             cfg_lock,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             wr_err,
    output logic [31:0]      cfg_regs,
    output logic             dup_flag,
    output logic [CNT_W-1:0] wr_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [7:0]       r_regs [4];
    logic [7:0]       r_rd_data;
    logic             r_rd_valid;
    logic             r_wr_err;
    logic [CNT_W-1:0] r_wr_cnt;

    logic             w_rd_acc;
    logic             w_wr_ok;
    logic             w_wr_rej;
    logic             w_dup;

    // Decode the access taken at this edge; direction bit makes read and
    // write mutually exclusive, and the lock only matters for writes.
    assign w_rd_acc = mem_en & ~mem_rd_wr;
    assign w_wr_ok  = mem_en &  mem_rd_wr & ~cfg_lock;
    assign w_wr_rej = mem_en &  mem_rd_wr &  cfg_lock;

    // Register file, read port, status pulses and saturating write counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= REG_RESET_VAL;
            end
            r_rd_data  <= 8'h00;
            r_rd_valid <= 1'b0;
            r_wr_err   <= 1'b0;
            r_wr_cnt   <= '0;
        end else begin
            r_rd_valid <= w_rd_acc;
            r_wr_err   <= w_wr_rej;
            if (w_rd_acc) begin
                r_rd_data <= r_regs[mem_add];
            end
            if (w_wr_ok) begin
                r_regs[mem_add] <= mem_data;
                if (r_wr_cnt != c_CNT_MAX) begin
                    r_wr_cnt <= r_wr_cnt + c_CNT_ONE;
                end
            end
        end
    end

    // Duplicate detector over all six register pairs, straight from state.
    always_comb begin
        w_dup = 1'b0;
        for (int i = 0; i < 3; i++) begin
            for (int j = i + 1; j < 4; j++) begin
                if (r_regs[i] == r_regs[j]) begin
                    w_dup = 1'b1;
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < 4; g++) begin : g_pack
            assign cfg_regs[8*g +: 8] = r_regs[g];
        end
    endgenerate

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign wr_err   = r_wr_err;
    assign wr_cnt   = r_wr_cnt;
    assign dup_flag = w_dup;

endmodule
`default_nettype wire
